// File: rtl/key_sched_ctrl_if.sv
// key_sched_ctrl_if
//  Bundles the host key handshake and the round-key read port of key_sched_ctrl.
//  Handshake: a key transfers on a rising clk edge where key_valid and key_ready
//  are both high. The host holds key_valid and key_in stable until that edge.
//  The block raises key_ready only when it is idle or done, and never queues keys.
//  Signals:
//   key_valid  host -> block   new cipher key offered on key_in
//   key_ready  block -> host   block can accept a key
//   key_in     host -> block   cipher key, word0 in [127:96]
//   busy       block -> host   expansion in progress
//   keys_valid block -> host   table complete for the last accepted key
//   done       block -> host   one-cycle pulse when the expansion completes
//   rk_idx     host -> block   round-key read index, 0..10
//   rk_out     block -> host   round key at slot rk_idx (combinational)
//   rk_err     block -> host   rk_idx out of range (combinational)
//  Modports: master = host / cipher datapath side, slave = key_sched_ctrl.
interface key_sched_ctrl_if #(parameter int KEY_W = 128);
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_in;
    logic             busy;
    logic             keys_valid;
    logic             done;
    logic [3:0]       rk_idx;
    logic [KEY_W-1:0] rk_out;
    logic             rk_err;

    modport master (
        output key_valid, key_in, rk_idx,
        input  key_ready, busy, keys_valid, done, rk_out, rk_err
    );

    modport slave (
        input  key_valid, key_in, rk_idx,
        output key_ready, busy, keys_valid, done, rk_out, rk_err
    );
endinterface

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl
//  Expands an AES-128 cipher key into the 11-slot round-key table, one key_gen
//  step per clock (slot 0 = cipher key, slots 1..10 = round keys), and serves any
//  slot through a combinational read port.
//  Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          key_sched_ctrl_if.slave (key handshake, status, read port)
//   dbg_state_o  FSM state: 0 = IDLE, 1 = EXPAND, 2 = DONE
module key_sched_ctrl #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_sched_ctrl_if.slave       bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e           state_q;
    logic [3:0]       rc_q;
    logic [KEY_W-1:0] cur_key_q;
    logic [KEY_W-1:0] slot_q [0:NR];
    logic             keys_valid_q;
    logic             done_q;
    logic [KEY_W-1:0] kg_out_d;

    // ---------------------------------------------------------------
    // key_gen: one AES-128 key-expansion step.
    // The S-box is computed as GF(2^8) inverse followed by the affine map,
    // which keeps the source short; the inverse is x^254 built from the
    // squares x^2, x^4, ... x^128.
    // ---------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] t;
        inv = 8'h01;
        t   = x;
        for (int i = 1; i < 8; i++) begin
            t   = gf_mul(t, t);
            inv = gf_mul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        logic [31:0] temp;
        logic [31:0] n0, n1, n2, n3;
        temp = sub_word({cur_key_q[23:0], cur_key_q[31:24]}) ^ {rcon(rc_q), 24'h0};
        n0   = cur_key_q[127:96] ^ temp;
        n1   = cur_key_q[95:64]  ^ n0;
        n2   = cur_key_q[63:32]  ^ n1;
        n3   = cur_key_q[31:0]   ^ n2;
        kg_out_d = {n0, n1, n2, n3};
    end

    // ---------------------------------------------------------------
    // Sequencer and table
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rc_q         <= 4'd0;
            cur_key_q    <= '0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i <= NR; i++) slot_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.key_valid) begin
                        slot_q[0]    <= bus.key_in;
                        cur_key_q    <= bus.key_in;
                        rc_q         <= 4'd0;
                        keys_valid_q <= 1'b0;
                        state_q      <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    slot_q[rc_q + 4'd1] <= kg_out_d;
                    cur_key_q           <= kg_out_d;
                    // rc stays at NR-1 after the last step so key_gen never
                    // sees an out-of-range round constant index.
                    if (rc_q == 4'(NR - 1)) begin
                        state_q      <= S_DONE;
                        keys_valid_q <= 1'b1;
                        done_q       <= 1'b1;
                    end else begin
                        rc_q <= rc_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.key_ready  = (state_q != S_EXPAND);
    assign bus.busy       = (state_q == S_EXPAND);
    assign bus.keys_valid = keys_valid_q;
    assign bus.done       = done_q;
    assign dbg_state_o    = state_q;

    always_comb begin
        bus.rk_out = '0;
        bus.rk_err = 1'b1;
        if (bus.rk_idx <= 4'(NR)) begin
            bus.rk_out = slot_q[bus.rk_idx];
            bus.rk_err = 1'b0;
        end
    end

endmodule
